// File: rtl/eth_ptp_rx_demux.sv
// Receive-side PTP/Ethernet demultiplexer: classifies each decoded frame
// by EtherType and destination MAC, then forwards, diverts or drops it.
module eth_ptp_rx_demux #(
  parameter logic [15:0] PTP_ETHERTYPE     = 16'h88F7,
  parameter int          ENABLE_MAC_FILTER = 1,
  parameter int          COUNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [47:0]            local_mac,

  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,
  input  logic [7:0]             s_eth_payload_axis_tdata,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic                   s_eth_payload_axis_tuser,

  output logic                   m_ptp_hdr_valid,
  input  logic                   m_ptp_hdr_ready,
  output logic [47:0]            m_ptp_src_mac,
  output logic [7:0]             m_ptp_payload_axis_tdata,
  output logic                   m_ptp_payload_axis_tvalid,
  input  logic                   m_ptp_payload_axis_tready,
  output logic                   m_ptp_payload_axis_tlast,
  output logic                   m_ptp_payload_axis_tuser,

  output logic                   m_eth_hdr_valid,
  input  logic                   m_eth_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [7:0]             m_eth_payload_axis_tdata,
  output logic                   m_eth_payload_axis_tvalid,
  input  logic                   m_eth_payload_axis_tready,
  output logic                   m_eth_payload_axis_tlast,
  output logic                   m_eth_payload_axis_tuser,

  output logic [COUNT_WIDTH-1:0] ptp_frame_count,
  output logic [COUNT_WIDTH-1:0] eth_frame_count,
  output logic [COUNT_WIDTH-1:0] drop_frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    PTP_HDR,
    PTP_PAYLOAD,
    ETH_HDR,
    ETH_PAYLOAD,
    DROP
  } state_e;

  state_e                 state_q;
  logic [47:0]            dest_q;
  logic [47:0]            src_q;
  logic [15:0]            type_q;
  logic [COUNT_WIDTH-1:0] ptp_cnt_q;
  logic [COUNT_WIDTH-1:0] eth_cnt_q;
  logic [COUNT_WIDTH-1:0] drop_cnt_q;

  logic accept;
  logic last_xfer;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Station, broadcast, PTP multicast and peer-delay multicast
  assign accept = (ENABLE_MAC_FILTER == 0)
               || (s_eth_dest_mac == local_mac)
               || (s_eth_dest_mac == 48'hFF_FF_FF_FF_FF_FF)
               || (s_eth_dest_mac == 48'h01_1B_19_00_00_00)
               || (s_eth_dest_mac == 48'h01_80_C2_00_00_0E);

  assign last_xfer = s_eth_payload_axis_tvalid
                  && s_eth_payload_axis_tready
                  && s_eth_payload_axis_tlast;

  assign s_eth_hdr_ready = (state_q == IDLE);

  always_comb begin
    s_eth_payload_axis_tready = 1'b0;
    unique case (state_q)
      PTP_PAYLOAD: s_eth_payload_axis_tready = m_ptp_payload_axis_tready;
      ETH_PAYLOAD: s_eth_payload_axis_tready = m_eth_payload_axis_tready;
      DROP:        s_eth_payload_axis_tready = 1'b1;
      default:     s_eth_payload_axis_tready = 1'b0;
    endcase
  end

  assign m_ptp_hdr_valid = (state_q == PTP_HDR);
  assign m_ptp_src_mac   = src_q;
  assign m_eth_hdr_valid = (state_q == ETH_HDR);
  assign m_eth_dest_mac  = dest_q;
  assign m_eth_src_mac   = src_q;
  assign m_eth_type      = type_q;

  assign m_ptp_payload_axis_tdata  = s_eth_payload_axis_tdata;
  assign m_ptp_payload_axis_tlast  = s_eth_payload_axis_tlast;
  assign m_ptp_payload_axis_tuser  = s_eth_payload_axis_tuser;
  assign m_ptp_payload_axis_tvalid = (state_q == PTP_PAYLOAD)
                                  && s_eth_payload_axis_tvalid;

  assign m_eth_payload_axis_tdata  = s_eth_payload_axis_tdata;
  assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser;
  assign m_eth_payload_axis_tvalid = (state_q == ETH_PAYLOAD)
                                  && s_eth_payload_axis_tvalid;

  assign ptp_frame_count  = ptp_cnt_q;
  assign eth_frame_count  = eth_cnt_q;
  assign drop_frame_count = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      ptp_cnt_q  <= '0;
      eth_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_eth_hdr_valid) begin
            dest_q <= s_eth_dest_mac;
            src_q  <= s_eth_src_mac;
            type_q <= s_eth_type;
            if (!accept)
              state_q <= DROP;
            else if (s_eth_type == PTP_ETHERTYPE)
              state_q <= PTP_HDR;
            else
              state_q <= ETH_HDR;
          end
        end
        PTP_HDR: begin
          if (m_ptp_hdr_ready) state_q <= PTP_PAYLOAD;
        end
        ETH_HDR: begin
          if (m_eth_hdr_ready) state_q <= ETH_PAYLOAD;
        end
        PTP_PAYLOAD: begin
          if (last_xfer) begin
            ptp_cnt_q <= sat_inc(ptp_cnt_q);
            state_q   <= IDLE;
          end
        end
        ETH_PAYLOAD: begin
          if (last_xfer) begin
            eth_cnt_q <= sat_inc(eth_cnt_q);
            state_q   <= IDLE;
          end
        end
        DROP: begin
          if (last_xfer) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_ptp_rx_demux.md
Name: eth_ptp_rx_demux

Overview:
Receive-side counterpart of the PTP/UDP transmit arbitration. It sits between eth_axis_rx and udp_complete on logic_clk. Each decoded Ethernet frame (header plus payload stream) is classified by EtherType and destination MAC, then steered to one of three paths:
- PTP-over-L2 frames go to the PTP payload output.
- All other accepted frames go to the Ethernet output feeding udp_complete.
- Frames failing the filter are dropped.
Saturating per-path frame counters are provided for debug.

Parameters:
PTP_ETHERTYPE, 16'h88F7, EtherType that classifies a frame as PTP
ENABLE_MAC_FILTER, 1, 1 = check destination MAC against the accept list; 0 = accept every destination
COUNT_WIDTH, 16, width of the frame counters

Ports:
clk  in  1  logic clock; one clock for the whole block
rst  in  1  synchronous, active-high reset
local_mac  in  48  station MAC for the destination filter
s_eth_hdr_valid  in  1  input header valid
s_eth_hdr_ready  out  1  input header ready
s_eth_dest_mac  in  48  destination MAC
s_eth_src_mac  in  48  source MAC
s_eth_type  in  16  EtherType
s_eth_payload_axis_tdata  in  8  payload data
s_eth_payload_axis_tvalid  in  1  payload valid
s_eth_payload_axis_tready  out  1  payload ready
s_eth_payload_axis_tlast  in  1  payload last
s_eth_payload_axis_tuser  in  1  payload error flag
m_ptp_hdr_valid  out  1  PTP header valid
m_ptp_hdr_ready  in  1  PTP header ready
m_ptp_src_mac  out  48  latched source MAC of the PTP frame
m_ptp_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  PTP payload stream
m_eth_hdr_valid  out  1  Ethernet header valid
m_eth_hdr_ready  in  1  Ethernet header ready
m_eth_dest_mac / m_eth_src_mac / m_eth_type  out  48/48/16  latched header fields
m_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  Ethernet payload stream
ptp_frame_count  out  COUNT_WIDTH  PTP frames forwarded
eth_frame_count  out  COUNT_WIDTH  Ethernet frames forwarded
drop_frame_count  out  COUNT_WIDTH  frames dropped

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE.
  - All valids are 0 and all counters are 0.
  - Latched header fields are 0.
  - s_eth_payload_axis_tready is 0.
  - s_eth_hdr_ready is 1 in the first cycle after reset.
- States: IDLE, PTP_HDR, PTP_PAYLOAD, ETH_HDR, ETH_PAYLOAD, DROP.
- IDLE:
  - s_eth_hdr_ready = 1 and s_eth_payload_axis_tready = 0.
  - On hdr handshake, latch dest, src and type, then classify in the same cycle:
    - accept = !ENABLE_MAC_FILTER, or dest in {local_mac, FF:FF:FF:FF:FF:FF, 01:1B:19:00:00:00, 01:80:C2:00:00:0E}.
    - type == PTP_ETHERTYPE and accept -> PTP_HDR.
    - type != PTP_ETHERTYPE and accept -> ETH_HDR.
    - !accept -> DROP.
- s_eth_hdr_ready is 0 in every state except IDLE.
- PTP_HDR / ETH_HDR:
  - The matching m_*_hdr_valid is registered and rises the cycle after the input header handshake (1-cycle header latency).
  - It is held with stable fields until the m_*_hdr_ready handshake.
  - After the handshake, go to the matching *_PAYLOAD state.
  - Payload is not accepted in these states: s tready = 0.
- PTP_PAYLOAD / ETH_PAYLOAD:
  - Combinational pass-through, zero latency.
  - m_x_tvalid = s_tvalid; s_tready = m_x_tready.
  - tdata, tlast and tuser pass through unchanged.
  - On a transfer with tlast: increment the matching counter and return to IDLE.
  - The next header is accepted no earlier than the following cycle (1-cycle bubble between frames).
- DROP:
  - s_tready = 1 and all m_* valids = 0.
  - On a transfer with tlast: increment drop_frame_count and return to IDLE.
- The non-selected output always has tvalid = 0; its tdata is don't-care.
- tuser = 1 on a last beat is forwarded as-is. The frame still counts on its path; there is no separate error count.
- Counters saturate at all-ones and never wrap.
- A zero-payload frame still has exactly one beat with tlast from eth_axis_rx, so it is handled like any other frame.
- Reset mid-frame:
  - Return to IDLE immediately and drop any pending header valid.
  - Remaining beats of the interrupted frame are not consumed; upstream is reset on the same rst.
- Downstream backpressure in the payload states stalls upstream only. No beat is lost or duplicated.

Test Plan:
- PTP frame, dest 01:1B:19:00:00:00, type 0x88F7, 44-byte payload, all readies high -> m_ptp_hdr_valid asserts 1 cycle after the input header handshake; 44 bytes appear on the PTP output with tlast on byte 44; ptp_frame_count = 1; m_eth valids never assert.
- UDP/IP frame, dest = local_mac, type 0x0800, 60 bytes; m_eth_payload_axis_tready toggles every cycle -> data on the eth output is identical and in order; eth_frame_count = 1; s_tready mirrors m_eth_payload_axis_tready.
- Frame with dest 02:00:00:00:00:99 ≠ local_mac, ENABLE_MAC_FILTER = 1 -> all payload consumed with tready = 1; no m_* valid; drop_frame_count = 1. Same frame with ENABLE_MAC_FILTER = 0 -> forwarded on eth output.
- m_ptp_hdr_ready held low 10 cycles with payload presented -> s_eth_payload_axis_tready stays 0 and header fields stay stable; after the header handshake the payload flows.
- Back-to-back PTP, ETH, PTP frames -> exactly one bubble cycle between frames; counters read ptp = 2, eth = 1; last beat carrying tuser = 1 is forwarded with tuser = 1.
- Assert rst mid PTP_PAYLOAD, then preload counters to 0xFFFF by driving 65 536 dropped frames, then one more drop -> after reset all valids are 0 and counters are 0; drop_frame_count holds at 0xFFFF (saturation).
